// File: rtl/layer_pkg.sv
// Shared constants for the layer sequencer: default sizes, the layer's weight
// matrix and biases, and the controller state encoding.
package layer_pkg;

  localparam int N_IN_DEF  = 10;
  localparam int N_OUT_DEF = 10;
  localparam int W_ACC_DEF = 20;

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  // Row 9 is the all-minimum row used to exercise worst-case accumulator growth.
  localparam logic signed [7:0] W [10][10] = '{
    '{ 8'sd43,   8'sd13,   8'sd124,  8'sd15,   8'sd20,   -8'sd36,  -8'sd5,   -8'sd26,  8'sd79,   8'sd106},
    '{-8'sd12,   8'sd55,   8'sd7,   -8'sd88,   8'sd31,    8'sd64,  -8'sd3,    8'sd19, -8'sd47,   8'sd22 },
    '{ 8'sd90,  -8'sd14,   8'sd36,  -8'sd61,   8'sd8,     8'sd27,  -8'sd99,   8'sd45,  8'sd3,   -8'sd20 },
    '{ 8'sd17,  -8'sd70,   8'sd58,   8'sd11,  -8'sd25,    8'sd102, -8'sd6,   -8'sd33,  8'sd74,   8'sd9  },
    '{-8'sd41,   8'sd29,  -8'sd17,   8'sd83,  -8'sd56,    8'sd12,   8'sd38,  -8'sd90,  8'sd5,    8'sd61 },
    '{ 8'sd66,  -8'sd8,   -8'sd44,   8'sd21,   8'sd97,   -8'sd19,   8'sd50,   8'sd14, -8'sd73,  -8'sd2  },
    '{ 8'sd3,    8'sd118, -8'sd27,  -8'sd52,   8'sd40,   -8'sd11,   8'sd9,    8'sd71, -8'sd35,   8'sd88 },
    '{-8'sd95,   8'sd24,   8'sd63,  -8'sd9,   -8'sd30,    8'sd47,   8'sd81,  -8'sd16,  8'sd28,  -8'sd57 },
    '{ 8'sd10,  -8'sd37,  -8'sd1,    8'sd105, -8'sd64,    8'sd33,  -8'sd22,   8'sd56, -8'sd84,   8'sd46 },
    '{ 8'sh80,   8'sh80,   8'sh80,   8'sh80,   8'sh80,    8'sh80,   8'sh80,   8'sh80,  8'sh80,   8'sh80 }
  };

  localparam logic signed [7:0] B [10] = '{
    8'sd27, -8'sd5, 8'sd12, 8'sd100, -8'sd20, 8'sd0, 8'sd60, -8'sd100, 8'sd127, -8'sd3
  };

endpackage

// File: rtl/layer_sequencer_if.sv
// Activation-in / neuron-result-out handshake bundle of the layer sequencer.
interface layer_sequencer_if #(
  parameter int N_IN = layer_pkg::N_IN_DEF
);

  logic                in_valid;
  logic                in_ready;
  logic [8*N_IN-1:0]   in_act;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic [3:0]          out_idx;

  modport master (
    output in_valid, in_act, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_act, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

endinterface

// File: rtl/mac_unit.sv
// Single multiply-accumulate shared by all neurons; loads a bias or adds one
// full-precision 8x8 signed product per enabled cycle.
module mac_unit
  import layer_pkg::*;
#(
  parameter int W_ACC = W_ACC_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic signed [7:0]       bias,
  input  logic                    en,
  input  logic signed [7:0]       act,
  input  logic signed [7:0]       wgt,
  output logic signed [W_ACC-1:0] acc_nxt
);

  logic signed [15:0]      prod_p0;
  logic signed [W_ACC-1:0] acc_p0;

  assign prod_p0 = act * wgt;
  assign acc_nxt = acc_p0 + {{(W_ACC-16){prod_p0[15]}}, prod_p0};

  // Stage p0: accumulator register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_p0 <= '0;
    end else if (clr) begin
      acc_p0 <= {{(W_ACC-8){bias[7]}}, bias};
    end else if (en) begin
      acc_p0 <= acc_nxt;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Time-shares one MAC across every neuron of a dense layer, emitting one
// clipped 0..127 result per neuron through a valid/ready handshake.
module layer_sequencer
  import layer_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int W_ACC = W_ACC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  output logic              busy,
  layer_sequencer_if.slave  bus
);

  localparam int              KW     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(N_IN - 1);
  localparam logic [3:0]      J_LAST = 4'(N_OUT - 1);

  state_t                  state;
  logic [KW-1:0]           k;
  logic [3:0]              j;
  logic signed [7:0]       act_q [N_IN];
  logic                    mac_clr;
  logic                    mac_en;
  logic [3:0]              bias_idx;
  logic signed [W_ACC-1:0] acc_nxt;

  function automatic logic [7:0] act_fn(input logic signed [W_ACC-1:0] a);
    if (a[W_ACC-1]) begin
      return 8'd0;
    end else if (a > W_ACC'(127)) begin
      return 8'd127;
    end
    return a[7:0];
  endfunction

  // The accumulator is preloaded on the same edge that enters MAC for a neuron.
  always_comb begin
    mac_en   = (state == MAC) && !flush;
    mac_clr  = 1'b0;
    bias_idx = '0;
    if (!flush) begin
      if (state == IDLE && bus.in_valid) begin
        mac_clr = 1'b1;
      end else if (state == EMIT && bus.out_ready && j != J_LAST) begin
        mac_clr  = 1'b1;
        bias_idx = j + 4'd1;
      end
    end
  end

  mac_unit #(.W_ACC(W_ACC)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (mac_clr),
    .bias    (B[bias_idx]),
    .en      (mac_en),
    .act     (act_q[k]),
    .wgt     (W[j][k]),
    .acc_nxt (acc_nxt)
  );

  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      j             <= '0;
      k             <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
    end else if (flush) begin
      state         <= IDLE;
      j             <= '0;
      k             <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_IN; i++) act_q[i] <= bus.in_act[8*i +: 8];
            j     <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (k == K_LAST) begin
            k             <= '0;
            bus.out_data  <= act_fn(acc_nxt);
            bus.out_idx   <= j;
            bus.out_valid <= 1'b1;
            state         <= EMIT;
          end else begin
            k <= k + 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            k             <= '0;
            if (j == J_LAST) begin
              j     <= '0;
              state <= IDLE;
            end else begin
              j     <= j + 4'd1;
              state <= MAC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized and directed checks of layer_sequencer against a plain-arithmetic
// dot-product reference model.
module tb_layer_sequencer;
  import layer_pkg::*;

  localparam int NI = 10;
  localparam int NO = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic busy;

  layer_sequencer_if #(.N_IN(NI)) bus ();

  layer_sequencer #(.N_IN(NI), .N_OUT(NO), .W_ACC(20)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .busy  (busy),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [7:0] va [NI];
  int out0;
  int out9;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int act_ref(input int acc);
    if (acc < 0)   return 0;
    if (acc > 127) return 127;
    return acc;
  endfunction

  function automatic int neuron_ref(input int jj);
    int s;
    s = int'(B[jj]);
    for (int kk = 0; kk < NI; kk++) s += int'(va[kk]) * int'(W[jj][kk]);
    return act_ref(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_vec();
    for (int i = 0; i < NI; i++) bus.in_act[8*i +: 8] = va[i];
  endtask

  task automatic scramble_in();
    for (int i = 0; i < NI; i++) bus.in_act[8*i +: 8] = 8'($urandom_range(0, 255));
  endtask

  task automatic rand_vec();
    for (int i = 0; i < NI; i++) va[i] = 8'($urandom_range(0, 255));
  endtask

  // mode 0: out_ready always high; 1: random back-pressure; 2: five-cycle stalls
  task automatic run_vector(input int mode);
    int cnt;
    int hold;
    int exp;
    chk("start_in_ready", int'(bus.in_ready), 1);
    pack_vec();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    scramble_in();
    for (int jj = 0; jj < NO; jj++) begin
      cnt = 0;
      while (!bus.out_valid && cnt < 40) begin
        if (mode != 0) bus.in_valid = 1'($urandom_range(0, 1));
        tick();
        cnt++;
      end
      bus.in_valid = 1'b0;
      exp = neuron_ref(jj);
      chk("latency", cnt, NI);
      chk("out_idx", int'(bus.out_idx), jj);
      chk("out_data", int'(bus.out_data), exp);
      chk("busy_in_ready", int'(bus.in_ready), 0);
      if (jj == 0)  out0 = int'(bus.out_data);
      if (jj == NO-1) out9 = int'(bus.out_data);
      hold = (mode == 0) ? 0 : (mode == 2) ? 5 : $urandom_range(0, 3);
      if (hold > 0) bus.out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_idx", int'(bus.out_idx), jj);
        chk("hold_data", int'(bus.out_data), exp);
        chk("hold_in_ready", int'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("valid_cleared", int'(bus.out_valid), 0);
    end
    chk("done_busy", int'(busy), 0);
    chk("done_in_ready", int'(bus.in_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int stale;
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_idx", int'(bus.out_idx), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    tick();
    chk("rst_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < NI; i++) va[i] = 8'sd0;
    run_vector(0);
    chk("zero_n0", out0, 27);

    va[1] = 8'sd1;
    run_vector(0);
    chk("row0_a1", out0, 40);

    va[1] = 8'sd0;
    va[5] = 8'sd1;
    run_vector(1);
    chk("row0_a5", out0, 0);

    for (int i = 0; i < NI; i++) va[i] = 8'sd1;
    run_vector(2);
    chk("row0_ones", out0, 127);

    for (int i = 0; i < NI; i++) va[i] = 8'sh80;
    run_vector(1);
    chk("row9_min", out9, 127);

    // Abort on the 4th MAC cycle of neuron 2 (accept edge + 26).
    rand_vec();
    pack_vec();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (25) tick();
    chk("flush_pos_idx", int'(bus.out_idx), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", int'(busy), 0);
    chk("flush_valid", int'(bus.out_valid), 0);
    chk("flush_in_ready", int'(bus.in_ready), 1);

    bus.in_valid = 1'b1;
    flush        = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    chk("flush_hs_busy", int'(busy), 0);

    rand_vec();
    run_vector(1);

    // Reset while neuron 5 is waiting in EMIT.
    rand_vec();
    pack_vec();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!(bus.out_valid && bus.out_idx == 4'd5) && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("rst_reach_n5", int'(bus.out_idx), 5);
    bus.out_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_valid", int'(bus.out_valid), 0);
    chk("async_data", int'(bus.out_data), 0);
    chk("async_idx", int'(bus.out_idx), 0);
    chk("async_busy", int'(busy), 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (30) begin
      tick();
      if (bus.out_valid) stale++;
    end
    chk("no_stale_valid", stale, 0);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    repeat (6) begin
      rand_vec();
      run_vector($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
